// File: rtl/vga_scan_generator.sv
// vga_scan_generator: VGA timing with 2x-scaled 320x240 frame-buffer addressing
// and a sync/enable pipeline matched to the frame-buffer read latency.
module vga_scan_generator #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int PIPE_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [16:0] pixel_address,
   input  logic [3:0]  vga_in,
   output logic [3:0]  color_out,
   output logic        hsync_n,
   output logic        vsync_n,
   output logic        de,
   output logic        frame_start
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL);
   localparam int VW = $clog2(V_TOTAL);
   localparam logic [HW-1:0] H_MAX  = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_MAX  = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [16:0]   ROW_STEP = 17'(H_ACTIVE / 2);

   logic [HW-1:0]       h, h_nxt;
   logic [VW-1:0]       v, v_nxt;
   logic [16:0]         row_base, row_nxt, addr_nxt;
   logic                h_wrap, hs_raw, vs_raw, act_raw;
   logic [PIPE_LAT-1:0] hs_d, vs_d, act_d;

   // Address is computed from the next counter values so the registered
   // pixel_address always matches the (h,v) the counters hold in that cycle.
   always_comb begin
      h_wrap   = h == H_MAX;
      h_nxt    = h_wrap ? '0 : h + 1'b1;
      v_nxt    = !h_wrap ? v : (v == V_MAX) ? '0 : v + 1'b1;
      row_nxt  = (v_nxt == '0) ? '0 :
                 (h_wrap && !v_nxt[0] && v_nxt < V_ACT) ? row_base + ROW_STEP : row_base;
      addr_nxt = (h_nxt < H_ACT && v_nxt < V_ACT) ? row_nxt + 17'(h_nxt[HW-1:1]) : '0;
      hs_raw   = !(h >= HS_BEG && h < HS_END);
      vs_raw   = !(v >= VS_BEG && v < VS_END);
      act_raw  = h < H_ACT && v < V_ACT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h             <= '0;
         v             <= '0;
         row_base      <= '0;
         pixel_address <= '0;
         frame_start   <= 1'b0;
         hs_d          <= '1;
         vs_d          <= '1;
         act_d         <= '0;
         hsync_n       <= 1'b1;
         vsync_n       <= 1'b1;
         de            <= 1'b0;
         color_out     <= '0;
      end else begin
         h             <= h_nxt;
         v             <= v_nxt;
         row_base      <= row_nxt;
         pixel_address <= addr_nxt;
         frame_start   <= h_wrap && v == V_MAX;
         hs_d[0]       <= hs_raw;
         vs_d[0]       <= vs_raw;
         act_d[0]      <= act_raw;
         for (int i = 1; i < PIPE_LAT; i++) begin
            hs_d[i]  <= hs_d[i-1];
            vs_d[i]  <= vs_d[i-1];
            act_d[i] <= act_d[i-1];
         end
         hsync_n       <= hs_d[PIPE_LAT-1];
         vsync_n       <= vs_d[PIPE_LAT-1];
         de            <= act_d[PIPE_LAT-1];
         color_out     <= act_d[PIPE_LAT-1] ? vga_in : 4'h0;
      end
   end
endmodule

// File: tb/tb_vga_scan_generator.sv
// tb_vga_scan_generator: three instances (PIPE_LAT 2, 1, 4) with a short
// vertical timing, each fed by its own frame-RAM latency model.
module tb_vga_scan_generator;
   localparam int VA = 8, VF = 1, VSW = 2, VB = 1;
   localparam int HT = 800, VT = VA + VF + VSW + VB, FRAME = HT * VT;

   logic clk = 1'b0, rst_n = 1'b0, force_f = 1'b0;
   always #5 clk = ~clk;

   logic [16:0] pa [3];
   logic [3:0]  vin [3], co [3];
   logic        hs [3], vs [3], de [3], fs [3];

   int n_cmp = 0, n_bad = 0;
   int hm, vm, c;
   logic       h_hs [8], h_vs [8], h_act [8];
   logic [3:0] h_col [8];
   int hs_low, vs_low, de_cnt, col_f, fs_n;
   int fs_at [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int lat(input int k);
      return k == 0 ? 2 : k == 1 ? 1 : 4;
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int L = g == 0 ? 2 : g == 1 ? 1 : 4;
      logic [3:0] pipe [4];
      always @(posedge clk) begin
         pipe[0] <= pa[g][3:0];
         for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
      assign vin[g] = force_f ? 4'hF : pipe[L-1];
      vga_scan_generator #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_LAT(L)) u_dut (
         .clk(clk), .rst_n(rst_n), .pixel_address(pa[g]), .vga_in(vin[g]), .color_out(co[g]),
         .hsync_n(hs[g]), .vsync_n(vs[g]), .de(de[g]), .frame_start(fs[g]));
   end

   task automatic model_reset();
      hm = 0; vm = 0; c = 0;
      hs_low = 0; vs_low = 0; de_cnt = 0; col_f = 0; fs_n = 0;
      fs_at[0] = -1; fs_at[1] = -1;
   endtask

   task automatic check_reset_vals(input string tag);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s_addr[%0d]", tag, k), pa[k], 0);
         check($sformatf("%s_hsync[%0d]", tag, k), hs[k], 1);
         check($sformatf("%s_vsync[%0d]", tag, k), vs[k], 1);
         check($sformatf("%s_de[%0d]", tag, k), de[k], 0);
         check($sformatf("%s_color[%0d]", tag, k), co[k], 0);
         check($sformatf("%s_fs[%0d]", tag, k), fs[k], 0);
      end
   endtask

   // Compare the current cycle against the reference, then advance it.
   task automatic step();
      logic act, e_hs, e_vs, e_act;
      logic [3:0] e_col;
      int a, j;
      act = hm < 640 && vm < VA;
      a = act ? (vm / 2) * 320 + hm / 2 : 0;
      for (int k = 0; k < 3; k++) begin
         if (c >= lat(k) + 1) begin
            j = (c - lat(k) - 1) % 8;
            e_hs = h_hs[j]; e_vs = h_vs[j]; e_act = h_act[j]; e_col = h_col[j];
         end else begin
            e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_col = 4'h0;
         end
         check($sformatf("addr[%0d]", k), pa[k], a);
         check($sformatf("hsync[%0d]", k), hs[k], e_hs);
         check($sformatf("vsync[%0d]", k), vs[k], e_vs);
         check($sformatf("de[%0d]", k), de[k], e_act);
         check($sformatf("color[%0d]", k), co[k], e_col);
         check($sformatf("fs[%0d]", k), fs[k], c > 0 && hm == 0 && vm == 0);
      end
      if (c == 2)           check("addr_h2", pa[0], 1);
      if (c == 640)         check("addr_blank", pa[0], 0);
      if (c == HT + 3)      check("addr_line1", pa[0], 1);
      if (c == 2 * HT)      check("addr_line2", pa[0], 320);
      if (c == 7 * HT + 639) check("addr_last", pa[0], 1279);
      if (c < HT && !hs[0]) hs_low++;
      if (c < FRAME) begin
         if (!vs[0]) vs_low++;
         if (de[0]) de_cnt++;
         if (co[0] == 4'hF) col_f++;
      end
      if (fs[0]) begin
         if (fs_n < 2) fs_at[fs_n] = c;
         fs_n++;
      end
      h_hs[c % 8]  = !(hm >= 656 && hm < 752);
      h_vs[c % 8]  = !(vm >= VA + VF && vm < VA + VF + VSW);
      h_act[c % 8] = act;
      h_col[c % 8] = act ? (force_f ? 4'hF : 4'(a % 16)) : 4'h0;
      c++;
      hm++;
      if (hm == HT) begin
         hm = 0;
         vm = (vm == VT - 1) ? 0 : vm + 1;
      end
   endtask

   initial begin
      int guard;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;
      model_reset();
      repeat (2 * FRAME + 10) begin
         step();
         @(negedge clk);
      end
      check("hs_low_line0", hs_low, 96);
      check("vs_low_frame0", vs_low, 1600);
      check("de_frame0", de_cnt, 5120);
      check("fs_count", fs_n, 2);
      check("fs_first", fs_at[0], FRAME);
      check("fs_second", fs_at[1], 2 * FRAME);
      guard = 0;
      while (!(hm == 400 && vm == 5) && guard < FRAME) begin
         step();
         @(negedge clk);
         guard++;
      end
      check("reach_400_5", guard < FRAME, 1);
      check("de_pre_rst", de[0], 1);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async");
      force_f = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (FRAME + 10) begin
         step();
         @(negedge clk);
      end
      check("fs_count_after_rst", fs_n, 1);
      check("fs_after_rst", fs_at[0], FRAME);
      check("color_f_frame", col_f, 5120);
      check("de_frame_after_rst", de_cnt, 5120);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
